// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 front-end constants and types used by the
//                fetch queue and its neighbours.
//                RV32_XLEN    - architectural register / PC width
//                RV32_NOP     - canonical NOP (addi x0,x0,0)
//                fetch_pair_t - {pc, code} pair as it travels fetch->decode
//  Revision    : 1.0 - initial multi-entry fetch queue release
// ============================================================================
package rv32_pkg;

    localparam int          RV32_XLEN = 32;
    localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [RV32_XLEN-1:0] pc;
        logic [31:0]          code;
    } fetch_pair_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_fetch_queue_if
//  Description : Handshake bundle between the PC unit / decode stage and the
//                fetch queue.
//                flush, in_valid, in_pc, in_code, out_ready : into the queue
//                in_ready, out_valid, out_pc, out_code,
//                count, almost_full                          : out of the queue
//                master - environment side (fetch + decode)
//                slave  - queue side
//  Revision    : 1.0 - initial multi-entry fetch queue release
// ============================================================================
interface rv32_fetch_queue_if
    import rv32_pkg::*;
#(
    parameter int XLEN  = RV32_XLEN,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_code;
    logic             in_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_code;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             almost_full;

    modport master (
        output flush, in_valid, in_pc, in_code, out_ready,
        input  in_ready, out_valid, out_pc, out_code, count, almost_full
    );

    modport slave (
        input  flush, in_valid, in_pc, in_code, out_ready,
        output in_ready, out_valid, out_pc, out_code, count, almost_full
    );

endinterface : rv32_fetch_queue_if
`default_nettype wire

// File: rtl/rv32_fetch_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_fetch_queue_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous (combinational) read port. Contents are not
//                reset; the owner masks unwritten entries.
//                clk   - write clock
//                we    - write enable
//                waddr - write address,  wdata - write data
//                raddr - read address,   rdata - read data (same cycle)
//  Revision    : 1.0 - initial multi-entry fetch queue release
// ============================================================================
module rv32_fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic [AW-1:0]    raddr,
    output logic      [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : rv32_fetch_queue_mem
`default_nettype wire

// File: rtl/rv32_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_fetch_queue
//  Description : Multi-entry show-ahead queue of {pc, instruction} pairs
//                between code fetch and decode. Presents NOP_INSTR / pc 0
//                when empty, flushes synchronously on redirect.
//                clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - rv32_fetch_queue_if.slave (push side, pop side,
//                        flush, occupancy count, almost_full)
//  Revision    : 1.0 - initial multi-entry fetch queue release
// ============================================================================
module rv32_fetch_queue
    import rv32_pkg::*;
#(
    parameter int          XLEN      = RV32_XLEN,
    parameter int          DEPTH     = 4,
    parameter int          AF_MARGIN = 1,
    parameter logic [31:0] NOP_INSTR = RV32_NOP
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rv32_fetch_queue_if.slave  bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PAIR_W = XLEN + 32;

    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF_THR  = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              push, pop, full, empty;
    logic [PAIR_W-1:0] rd_pair;

    // Full/empty come only from registered count, so in_ready never depends
    // on out_ready: a pop in the same cycle does not free a slot for a push.
    always_comb begin
        full     = (count_q == C_DEPTH);
        empty    = (count_q == '0);
        push     = bus.in_valid  & ~full  & ~bus.flush;
        pop      = bus.out_ready & ~empty & ~bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    rv32_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({bus.in_pc, bus.in_code}),
        .raddr (rd_ptr_q),
        .rdata (rd_pair)
    );

    // Unwritten storage may hold X; the empty mask keeps head outputs clean.
    assign bus.out_valid   = ~empty;
    assign bus.out_pc      = empty ? '0        : rd_pair[PAIR_W-1:32];
    assign bus.out_code    = empty ? NOP_INSTR : rd_pair[31:0];
    assign bus.in_ready    = ~full;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= C_AF_THR);

endmodule : rv32_fetch_queue
`default_nettype wire

// File: tb/tb_rv32_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_fetch_queue
//  Description : Self-checking bench for rv32_fetch_queue. Four instances
//                (DEPTH/AF_MARGIN = 4/1, 2/0, 8/0, 8/2) share one stimulus
//                stream; a queue-based model per instance supplies expected
//                outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_pc, in_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus0 ();
    rv32_fetch_queue_if #(.XLEN(32), .DEPTH(2)) bus1 ();
    rv32_fetch_queue_if #(.XLEN(32), .DEPTH(8)) bus2 ();
    rv32_fetch_queue_if #(.XLEN(32), .DEPTH(8)) bus3 ();

    assign bus0.flush = flush; assign bus0.in_valid = in_valid; assign bus0.in_pc = in_pc;
    assign bus0.in_code = in_code; assign bus0.out_ready = out_ready;
    assign bus1.flush = flush; assign bus1.in_valid = in_valid; assign bus1.in_pc = in_pc;
    assign bus1.in_code = in_code; assign bus1.out_ready = out_ready;
    assign bus2.flush = flush; assign bus2.in_valid = in_valid; assign bus2.in_pc = in_pc;
    assign bus2.in_code = in_code; assign bus2.out_ready = out_ready;
    assign bus3.flush = flush; assign bus3.in_valid = in_valid; assign bus3.in_pc = in_pc;
    assign bus3.in_code = in_code; assign bus3.out_ready = out_ready;

    rv32_fetch_queue #(.XLEN(32), .DEPTH(4), .AF_MARGIN(1), .NOP_INSTR(NOP))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rv32_fetch_queue #(.XLEN(32), .DEPTH(2), .AF_MARGIN(0), .NOP_INSTR(NOP))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    rv32_fetch_queue #(.XLEN(32), .DEPTH(8), .AF_MARGIN(0), .NOP_INSTR(NOP))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    rv32_fetch_queue #(.XLEN(32), .DEPTH(8), .AF_MARGIN(2), .NOP_INSTR(NOP))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Per-instance observed outputs, count zero-extended to 4 bits.
    logic        a_val [4];
    logic        a_rdy [4];
    logic        a_af  [4];
    logic [3:0]  a_cnt [4];
    logic [31:0] a_pc  [4];
    logic [31:0] a_code[4];

    assign a_val[0] = bus0.out_valid; assign a_rdy[0] = bus0.in_ready; assign a_af[0] = bus0.almost_full;
    assign a_cnt[0] = {1'b0, bus0.count}; assign a_pc[0] = bus0.out_pc; assign a_code[0] = bus0.out_code;
    assign a_val[1] = bus1.out_valid; assign a_rdy[1] = bus1.in_ready; assign a_af[1] = bus1.almost_full;
    assign a_cnt[1] = {2'b0, bus1.count}; assign a_pc[1] = bus1.out_pc; assign a_code[1] = bus1.out_code;
    assign a_val[2] = bus2.out_valid; assign a_rdy[2] = bus2.in_ready; assign a_af[2] = bus2.almost_full;
    assign a_cnt[2] = bus2.count;         assign a_pc[2] = bus2.out_pc; assign a_code[2] = bus2.out_code;
    assign a_val[3] = bus3.out_valid; assign a_rdy[3] = bus3.in_ready; assign a_af[3] = bus3.almost_full;
    assign a_cnt[3] = bus3.count;         assign a_pc[3] = bus3.out_pc; assign a_code[3] = bus3.out_code;

    // Reference model: a plain FIFO of {pc, code} per instance.
    logic [63:0] mq [4][$];
    int m_depth[4] = '{4, 2, 8, 8};
    int m_thr  [4] = '{4 - 1, 2 - 0, 8 - 0, 8 - 2};

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
    endtask

    // Applies one clock edge worth of the current inputs to every model.
    task automatic model_edge();
        bit do_pop, do_push;
        for (int k = 0; k < 4; k++) begin
            if (flush) begin
                mq[k].delete();
            end else begin
                do_pop  = (mq[k].size() != 0) && out_ready;
                do_push = in_valid && (mq[k].size() < m_depth[k]);
                if (do_pop)  void'(mq[k].pop_front());
                if (do_push) mq[k].push_back({in_pc, in_code});
            end
        end
    endtask

    // Expected {out_valid, in_ready, almost_full, count[3:0], out_pc, out_code}.
    function automatic logic [70:0] model_exp(input int k);
        int          n;
        logic [63:0] head;
        logic [31:0] pc, code;
        n = mq[k].size();
        if (n != 0) begin
            head = mq[k][0];
            pc   = head[63:32];
            code = head[31:0];
        end else begin
            pc   = '0;
            code = NOP;
        end
        return {n != 0, n < m_depth[k], n >= m_thr[k], 4'(n), pc, code};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_code = '0;
        @(negedge clk);
        rst_n = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [70:0] exp_v, act_v;
        do_reset();
        in_valid = 1; in_pc = 32'h40; in_code = 32'h55; tick();
        in_pc = 32'h44; tick();
        in_valid = 0;
        #2;
        rst_n = 0;
        model_clear();
        #1;
        total++; if (a_val[0] !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", a_val[0]); end
        total++; if (a_code[0] !== NOP) begin bad++; $display("FAIL rst_out_code got=%h want=%h", a_code[0], NOP); end
        total++; if (a_pc[0] !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", a_pc[0]); end
        total++; if (a_cnt[0] !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", a_cnt[0]); end
        total++; if (a_rdy[0] !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", a_rdy[0]); end
        total++; if (a_af[0] !== 1'b0) begin bad++; $display("FAIL rst_almost_full got=%b want=0", a_af[0]); end
        @(negedge clk);
        out_ready = 1; in_valid = 0; rst_n = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_v = model_exp(k);
            act_v = {a_val[k], a_rdy[k], a_af[k], a_cnt[k], a_pc[k], a_code[k]};
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL post_reset_state inst=%0d got=%h want=%h", k, act_v, exp_v);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill_full();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_pc = 32'(4 * i); in_code = 32'(8'hA0 + i);
            tick();
            total++;
            if (a_cnt[0] !== 4'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, a_cnt[0], i + 1); end
            total++;
            if (a_af[0] !== (i + 1 >= 3)) begin bad++; $display("FAIL fill_almost_full i=%0d got=%b want=%b", i, a_af[0], (i + 1 >= 3)); end
        end
        total++; if (a_rdy[0] !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", a_rdy[0]); end
        in_pc = 32'h10; in_code = 32'hA4;
        tick();
        total++; if (a_cnt[0] !== 4'd4) begin bad++; $display("FAIL full_drop_count got=%0d want=4", a_cnt[0]); end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a_pc[0] !== 32'(4 * i) || a_code[0] !== 32'(8'hA0 + i)) begin
                bad++; $display("FAIL drain_head i=%0d got=%h/%h want=%h/%h", i, a_pc[0], a_code[0], 4 * i, 8'hA0 + i);
            end
            tick();
        end
        total++;
        if (a_val[0] !== 1'b0 || a_code[0] !== NOP || a_pc[0] !== 32'h0 || a_cnt[0] !== 4'd0) begin
            bad++; $display("FAIL drain_empty got v=%b code=%h pc=%h cnt=%0d want v=0 code=%h pc=0 cnt=0",
                            a_val[0], a_code[0], a_pc[0], a_cnt[0], NOP);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        do_reset();
        out_ready = 0; in_valid = 1;
        in_pc = 32'h100; in_code = 32'hB00; tick();
        in_pc = 32'h104; in_code = 32'hB01; tick();
        out_ready = 1;
        for (int i = 2; i < 12; i++) begin
            in_pc = 32'h100 + 32'(4 * i); in_code = 32'hB00 + 32'(i);
            total++;
            if (a_pc[0] !== 32'h100 + 32'(4 * (i - 2)) || a_code[0] !== 32'hB00 + 32'(i - 2)) begin
                bad++; $display("FAIL wrap_head i=%0d got=%h/%h want=%h/%h", i, a_pc[0], a_code[0],
                                32'h100 + 32'(4 * (i - 2)), 32'hB00 + 32'(i - 2));
            end
            tick();
            total++;
            if (a_cnt[0] !== 4'd2) begin bad++; $display("FAIL wrap_count i=%0d got=%0d want=2", i, a_cnt[0]); end
        end
        in_valid = 0;
        for (int j = 0; j < 2; j++) begin
            total++;
            if (a_pc[0] !== 32'h100 + 32'(4 * (10 + j))) begin
                bad++; $display("FAIL wrap_tail j=%0d got=%h want=%h", j, a_pc[0], 32'h100 + 32'(4 * (10 + j)));
            end
            tick();
        end
        total++; if (a_val[0] !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", a_val[0]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        do_reset();
        out_ready = 0; in_valid = 1;
        in_pc = 32'h20; in_code = 32'hC20; tick();
        in_pc = 32'h24; in_code = 32'hC24; tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (a_pc[0] !== 32'h20 || a_code[0] !== 32'hC20) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h want=20/c20", i, a_pc[0], a_code[0]);
            end
        end
        out_ready = 1;
        tick();
        total++;
        if (a_pc[0] !== 32'h24 || a_code[0] !== 32'hC24 || a_cnt[0] !== 4'd1) begin
            bad++; $display("FAIL stall_resume got=%h/%h cnt=%0d want=24/c24 cnt=1", a_pc[0], a_code[0], a_cnt[0]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        do_reset();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h30 + 32'(4 * i); in_code = 32'hD30 + 32'(i); tick();
        end
        flush = 1; in_valid = 1; in_pc = 32'h3C; in_code = 32'hD3C; out_ready = 1;
        #1;
        total++;
        if (a_pc[0] !== 32'h30 || a_cnt[0] !== 4'd3) begin
            bad++; $display("FAIL flush_cycle_hold got pc=%h cnt=%0d want pc=30 cnt=3", a_pc[0], a_cnt[0]);
        end
        tick();
        flush = 0; in_valid = 1; in_pc = 32'h200; in_code = 32'hE00;
        total++;
        if (a_cnt[0] !== 4'd0 || a_code[0] !== NOP || a_val[0] !== 1'b0) begin
            bad++; $display("FAIL flush_empty got cnt=%0d code=%h v=%b want cnt=0 code=%h v=0", a_cnt[0], a_code[0], a_val[0], NOP);
        end
        tick();
        in_valid = 0;
        total++;
        if (a_pc[0] !== 32'h200 || a_code[0] !== 32'hE00 || a_cnt[0] !== 4'd1) begin
            bad++; $display("FAIL flush_redirect got=%h/%h cnt=%0d want=200/e00 cnt=1", a_pc[0], a_code[0], a_cnt[0]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_param_sweep();
        logic [70:0] exp_v, act_v;
        do_reset();
        // Directed fill past every depth, then drain.
        out_ready = 0; in_valid = 1;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) begin in_valid = 0; out_ready = 1; end
            in_pc = 32'h300 + 32'(4 * c); in_code = 32'hF00 + 32'(c);
            tick();
            for (int k = 0; k < 4; k++) begin
                exp_v = model_exp(k);
                act_v = {a_val[k], a_rdy[k], a_af[k], a_cnt[k], a_pc[k], a_code[k]};
                total++;
                if (act_v !== exp_v) begin
                    bad++; $display("FAIL sweep_fill_drain inst=%0d cyc=%0d got=%h want=%h", k, c, act_v, exp_v);
                end
            end
        end
        // Randomised traffic with occasional redirects.
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_code   = $urandom;
            tick();
            for (int k = 0; k < 4; k++) begin
                exp_v = model_exp(k);
                act_v = {a_val[k], a_rdy[k], a_af[k], a_cnt[k], a_pc[k], a_code[k]};
                total++;
                if (act_v !== exp_v) begin
                    bad++; $display("FAIL sweep_random inst=%0d cyc=%0d got=%h want=%h", k, c, act_v, exp_v);
                end
            end
        end
        flush = 0; in_valid = 0; out_ready = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_code = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        test_reset();
        test_fill_full();
        test_wrap();
        test_stall();
        test_flush();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rv32_fetch_queue
`default_nettype wire
